// File: rtl/sys_bridge.sv
// sys_bridge: decodes the MIPS core's Pr* bus into N_DEV peripheral windows
// plus one internal register window. It adds a req/ready handshake with device
// wait states and a timeout, error signalling for unmapped addresses, and an
// interrupt mask that gates DevIrq onto HWInt[7:2].
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   PrAddr/BE/PrWD/     CPU word address, byte enables, write data,
//   PrWe/PrReq          write flag, request
//   PrRD/PrRdy/PrErr    read data, one-cycle completion strobe, error flag
//   HWInt[7:2]          masked interrupt lines to CP0
//   DevAddr/DevBE/      word offset in window, byte enables, write data,
//   DevWD/DevWe/DevSel  write strobe, one-hot device select
//   DevRD/DevAck/DevIrq per-device read data, completion, level interrupt
module sys_bridge #(
  parameter int unsigned N_DEV   = 2,
  parameter logic [31:0] BASE    = 32'h0000_7F00,
  parameter int unsigned DEV_AW  = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:2]           PrAddr,
  input  logic [3:0]            BE,
  input  logic [31:0]           PrWD,
  input  logic                  PrWe,
  input  logic                  PrReq,
  output logic [31:0]           PrRD,
  output logic                  PrRdy,
  output logic                  PrErr,
  output logic [7:2]            HWInt,
  output logic [DEV_AW-1:0]     DevAddr,
  output logic [3:0]            DevBE,
  output logic [31:0]           DevWD,
  output logic                  DevWe,
  output logic [N_DEV-1:0]      DevSel,
  input  logic [N_DEV*32-1:0]   DevRD,
  input  logic [N_DEV-1:0]      DevAck,
  input  logic [N_DEV-1:0]      DevIrq
);

  localparam int unsigned WIN_SHIFT = DEV_AW + 2;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned HW_W      = 6;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                state_q,   state_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [31:0]           prrd_q,    prrd_d;
  logic                  prrdy_q,   prrdy_d;
  logic                  prerr_q,   prerr_d;
  logic [HW_W-1:0]       hwint_q,   hwint_d;
  logic [DEV_AW-1:0]     dev_addr_q, dev_addr_d;
  logic [3:0]            dev_be_q,  dev_be_d;
  logic [31:0]           dev_wd_q,  dev_wd_d;
  logic                  dev_we_q,  dev_we_d;
  logic [N_DEV-1:0]      dev_sel_q, dev_sel_d;
  logic [N_DEV-1:0]      imask_q,   imask_d;

  // Address decode
  logic [31:0]           byte_addr;
  logic [31:0]           rel_addr;
  logic [31:0]           win_idx;
  logic                  below_base;
  logic                  dev_hit;
  logic                  int_hit;
  logic [DEV_AW-1:0]     word_off;
  logic [N_DEV-1:0]      dev_onehot;

  always_comb begin
    byte_addr  = {PrAddr, 2'b00};
    rel_addr   = byte_addr - BASE;
    win_idx    = rel_addr >> WIN_SHIFT;
    below_base = (byte_addr < BASE);
    dev_hit    = !below_base && (win_idx < 32'(N_DEV));
    int_hit    = !below_base && (win_idx == 32'(N_DEV));
    word_off   = rel_addr[WIN_SHIFT-1:2];
    dev_onehot = N_DEV'(1) << win_idx;
  end

  // Internal register read mux: offset 0 IMASK, offset 1 raw DevIrq, rest zero
  logic [31:0] int_rd;

  always_comb begin
    int_rd = 32'd0;
    if (word_off == DEV_AW'(0)) begin
      int_rd = 32'(imask_q);
    end else if (word_off == DEV_AW'(1)) begin
      int_rd = 32'(DevIrq);
    end
  end

  // Ack and read data of the currently selected device only
  logic [31:0] sel_rd;
  logic        ack_sel;

  always_comb begin
    sel_rd  = 32'd0;
    ack_sel = |(DevAck & dev_sel_q);
    for (int i = 0; i < int'(N_DEV); i++) begin
      if (dev_sel_q[i]) begin
        sel_rd = sel_rd | DevRD[32*i +: 32];
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prrd_d     = prrd_q;
    prrdy_d    = 1'b0;
    prerr_d    = prerr_q;
    dev_addr_d = dev_addr_q;
    dev_be_d   = dev_be_q;
    dev_wd_d   = dev_wd_q;
    dev_we_d   = dev_we_q;
    dev_sel_d  = dev_sel_q;
    imask_d    = imask_q;
    hwint_d    = HW_W'(DevIrq & imask_q);

    unique case (state_q)
      S_IDLE: begin
        if (PrReq) begin
          if (dev_hit) begin
            state_d    = S_ACCESS;
            cnt_d      = '0;
            dev_sel_d  = dev_onehot;
            dev_addr_d = word_off;
            dev_be_d   = BE;
            dev_wd_d   = PrWD;
            dev_we_d   = PrWe;
          end else if (int_hit) begin
            state_d = S_DONE;
            prrdy_d = 1'b1;
            prerr_d = 1'b0;
            prrd_d  = PrWe ? 32'd0 : int_rd;
            if (PrWe && (word_off == DEV_AW'(0)) && BE[0]) begin
              imask_d = PrWD[N_DEV-1:0];
            end
          end else begin
            state_d = S_DONE;
            prrdy_d = 1'b1;
            prerr_d = 1'b1;
            prrd_d  = 32'd0;
          end
        end
      end

      S_ACCESS: begin
        // An ack in the final allowed cycle still wins over the timeout
        if (ack_sel) begin
          state_d   = S_DONE;
          prrdy_d   = 1'b1;
          prerr_d   = 1'b0;
          prrd_d    = dev_we_q ? 32'd0 : sel_rd;
          dev_sel_d = '0;
          dev_we_d  = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = S_DONE;
          prrdy_d   = 1'b1;
          prerr_d   = 1'b1;
          prrd_d    = 32'd0;
          dev_sel_d = '0;
          dev_we_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      prrd_q     <= 32'd0;
      prrdy_q    <= 1'b0;
      prerr_q    <= 1'b0;
      hwint_q    <= '0;
      dev_addr_q <= '0;
      dev_be_q   <= 4'd0;
      dev_wd_q   <= 32'd0;
      dev_we_q   <= 1'b0;
      dev_sel_q  <= '0;
      imask_q    <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prrd_q     <= prrd_d;
      prrdy_q    <= prrdy_d;
      prerr_q    <= prerr_d;
      hwint_q    <= hwint_d;
      dev_addr_q <= dev_addr_d;
      dev_be_q   <= dev_be_d;
      dev_wd_q   <= dev_wd_d;
      dev_we_q   <= dev_we_d;
      dev_sel_q  <= dev_sel_d;
      imask_q    <= imask_d;
    end
  end

  assign PrRD    = prrd_q;
  assign PrRdy   = prrdy_q;
  assign PrErr   = prerr_q;
  assign HWInt   = hwint_q;
  assign DevAddr = dev_addr_q;
  assign DevBE   = dev_be_q;
  assign DevWD   = dev_wd_q;
  assign DevWe   = dev_we_q;
  assign DevSel  = dev_sel_q;

endmodule

// File: doc/sys_bridge.md
# sys_bridge

Parametrised system bridge between the multi-cycle MIPS core's processor bus and up to six memory-mapped peripherals. It adds things the current direct-wired bus lacks: address decode into N_DEV windows, a request/ready handshake with device wait states and timeout, error signalling for unmapped addresses, and an internal interrupt-mask register that gates peripheral interrupts onto the core's HWInt[7:2]. It sits between the core's Pr* bus and the peripherals, for example the timers.

## Interface
Parameters:
- N_DEV, 2, number of device windows (1..6)
- BASE, 32'h0000_7F00, byte base address of window 0 (aligned to 2^(DEV_AW+2))
- DEV_AW, 2, word-address bits per window; window size is 2^DEV_AW words
- TIMEOUT, 16, ACCESS cycles without ack before error (2..255)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- PrAddr  in  30  [31:2] CPU word address
- BE  in  4  CPU byte enables
- PrWD  in  32  CPU write data
- PrWe  in  1  1 = write, 0 = read
- PrReq  in  1  transaction request
- PrRD  out  32  read data to CPU
- PrRdy  out  1  one-cycle completion strobe
- PrErr  out  1  error flag, valid with PrRdy
- HWInt  out  6  [7:2] masked interrupt lines to CP0
- DevAddr  out  DEV_AW  word offset within window
- DevBE  out  4  byte enables to device
- DevWD  out  32  write data to device
- DevWe  out  1  write strobe
- DevSel  out  N_DEV  one-hot device select
- DevRD  in  N_DEV*32  device read data; device i on bits [32i+31:32i]
- DevAck  in  N_DEV  device completion
- DevIrq  in  N_DEV  level interrupt requests

## Operation
- Window index idx = ({PrAddr,2'b00} - BASE) >> (DEV_AW+2). Address below BASE or idx > N_DEV is unmapped. idx < N_DEV selects device idx. idx == N_DEV selects the internal register window.
- Internal registers, by word offset:
  - 0: IMASK[N_DEV-1:0], read/write. A write takes effect only if BE[0]=1. Reset value is all ones.
  - 1: IPEND, read-only raw DevIrq.
  - Other offsets read 0 and ignore writes. No error is raised for them.
- FSM states IDLE, ACCESS, DONE. Reset state is IDLE.
- IDLE, PrReq=1:
  - Device hit: register DevSel, DevAddr, DevBE, DevWD, DevWe=PrWe; clear the timeout counter; go to ACCESS.
  - Internal hit: perform the read or write and go to DONE.
  - Unmapped: set PrErr, set PrRD=0, go to DONE.
- ACCESS:
  - DevAck[sel]=1: capture DevRD slice sel into PrRD (0 for writes) and go to DONE. The device commits a write on this same edge.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without ack, set PrErr, set PrRD=0 and go to DONE.
  - Ack bits of non-selected devices are ignored.
- DONE: PrRdy=1 for exactly one cycle. DevSel, DevWe = 0. Next state is IDLE.
- PrReq deasserted mid-transaction: the transaction still completes and PrRdy still pulses. The CPU must hold address and data until PrRdy.
- PrReq held high after PrRdy starts a new transaction from IDLE on the following edge.
- HWInt[2+i] = registered (DevIrq[i] & IMASK[i]). Bits at or above 2+N_DEV are 0.

## Timing
- Reset: PrRD=0, PrRdy=0, PrErr=0, HWInt=0, DevSel=0, DevWe=0, DevAddr=0, DevBE=0, DevWD=0, IMASK all ones, counter 0, state IDLE. A reset during ACCESS aborts the access immediately, with no PrRdy.
- All outputs are registered; there is no combinational path from Pr* or Dev* inputs to any output.
- Device access, zero wait states: PrReq sampled at edge 0. ACCESS with DevSel high during cycle 1. DevAck high in cycle 1 is sampled at edge 2. PrRdy/PrRD valid in cycle 2. Minimum latency is 2 cycles.
- Each wait cycle adds 1. A timeout gives PrRdy with PrErr in cycle TIMEOUT+1.
- Internal or unmapped access: PrRdy in cycle 1.
- PrErr and PrRD hold their values until the next transaction completes. PrRdy is a 1-cycle pulse.
- An IMASK write affects HWInt from the cycle after PrRdy.
- DevIrq-to-HWInt latency is 1 cycle.

## Test plan
- Read dev 1 (N_DEV=2, BASE=0x7F00): PrAddr=0x7F14>>2, dev1 acks in cycle 1 with DevRD=0xCAFE0001 -> DevSel=2'b10, DevAddr=1, PrRdy in cycle 2, PrRD=0xCAFE0001, PrErr=0.
- Write dev 0 with 3 wait states: PrWD=0x12345678, BE=4'hF -> DevWe=1 and DevSel=01 for 4 cycles, PrRdy in cycle 5, DevWe=0 in DONE.
- Timeout (TIMEOUT=16): dev 0 never acks -> PrRdy with PrErr=1 and PrRD=0 in cycle 17.
- Unmapped reads at 0x7F30 and at 0x0000_1000 -> PrRdy in cycle 1, PrErr=1, DevSel stays 0.
- Interrupts: DevIrq=2'b11 -> HWInt=6'b000011 one cycle later. Write IMASK=0x1 at 0x7F20 -> HWInt=6'b000001. Read 0x7F24 -> PrRD=3.
- rst low during ACCESS -> all outputs 0 asynchronously, no PrRdy, IMASK back to 2'b11. A new read after release completes normally.
